muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for MIPS MULT, MULTU, DIV and DIVU, plus the HI/LO register pair read by MFHI/MFLO and written by MTHI/MTLO.
- Sits beside the main ALU. It is started by the decode/ALU-control stage and drives a stall back to the pipeline while an operation is in flight.
- Uses an iterative radix-2 shift-add multiplier and a restoring divider, one bit per clock.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new mul/div operation; sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  multiplicand or dividend.
- rt_val  in  WIDTH  multiplier or divisor.
- flush  in  1  cancel any in-flight operation (branch or exception squash).
- rd_req  in  1  MFHI/MFLO is in the read stage this cycle.
- wr_en  in  1  MTHI/MTLO write request.
- wr_sel  in  1  target of wr_en: 0 LO, 1 HI.
- wr_data  in  WIDTH  data for MTHI/MTLO.
- hi  out  WIDTH  HI register (remainder or upper product).
- lo  out  WIDTH  LO register (quotient or lower product).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO take a new mul/div result.
- stall  out  1  hold the pipeline.

Behaviour:
- Reset (asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operand registers=0. Reset during CALC or FIX aborts the operation; no result is written.
- States and transitions:
  - IDLE: when start=1 and flush=0, latch magnitudes of rs_val/rt_val (two's-complement negate for signed ops when the MSB is set), latch the result sign bits and the divide-by-zero flag (rt_val==0, divide ops only), clear counter, go to CALC. busy goes to 1 at this edge.
  - CALC: one iteration per clock for exactly WIDTH clocks. The counter increments each edge; on the edge where counter==WIDTH-1, go to FIX.
    - Multiply: 2*WIDTH-bit accumulator, add then shift.
    - Divide: restoring shift-subtract on remainder/quotient registers.
  - FIX: one clock. Apply sign correction. At this edge write hi/lo, set done=1 and busy=0, then go to IDLE.
- Latency: with start accepted on edge E0, results appear and done is high in the cycle after edge E(WIDTH+1), which is 34 clocks for WIDTH=32. busy is high from E0 through E(WIDTH+1).
- Sign rules:
  - Signed product sign = rs[MSB] XOR rt[MSB].
  - Quotient sign = rs[MSB] XOR rt[MSB].
  - Remainder sign follows the dividend.
  - Unsigned ops apply no correction.
- Boundary conditions:
  - DIV -2^(WIDTH-1) / -1: lo=0x80000000, hi=0 (natural wrap, no trap).
  - Divide by zero (either signedness): still takes full latency; hi=rs_val, lo=all ones.
  - start while busy: ignored; there is no queue.
  - start and flush in the same IDLE cycle: start ignored.
  - flush during CALC or FIX: return to IDLE on the next edge; busy=0; done stays 0; hi/lo unchanged.
- stall = busy & (start | rd_req | wr_en), combinational. MTHI/MTLO is held until the operation completes.
- wr_en with busy=0: update the selected register at the edge.
- wr_en in the same cycle that FIX writes: the FIX result wins; the write is blocked anyway because stall=1.
- hi/lo are register outputs and are stable except at FIX writes, wr_en writes and reset.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> after 34 clocks done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy low the same cycle.
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE. MULT with the same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=0 -> hi=0x00000064, lo=0xFFFFFFFF.
- rd_req held during an in-flight DIV -> stall=1 every cycle until done; a second start mid-op is ignored; hi/lo match only the first op.
- flush at CALC cycle 10, then reset asserted mid-op on a new MULT -> no done pulse; hi/lo keep prior values after flush; after reset, hi=lo=0, busy=0, IDLE.
- MTHI 0x12345678 while idle -> hi updates at the next edge, stall=0. MTLO issued while busy -> stall=1 and lo is unchanged until done.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side bundle of the mul/div sequencer: operation request, MTHI/MTLO
// write port, MFHI/MFLO read notification, and the HI/LO/status results.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             rd_req;
  logic             wr_en;
  logic             wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  // Pipeline side: issues operations and register moves, observes results.
  modport master (
    output start, op, rs_val, rt_val, flush, rd_req, wr_en, wr_sel, wr_data,
    input  hi, lo, busy, done, stall
  );

  // Sequencer side.
  modport slave (
    input  start, op, rs_val, rt_val, flush, rd_req, wr_en, wr_sel, wr_data,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU engine with the HI/LO register pair.
// Operands are reduced to magnitudes on acceptance, processed one bit per
// clock (shift-add multiply, restoring divide) for WIDTH clocks, then the
// result signs are restored in a single FIX clock that writes HI/LO.
// The interface instance must be built with the same WIDTH as this module.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  // Multiply: {upper product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               accept;
  logic               signed_op;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Conditional two's-complement negate on a single-width word.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x,
                                             input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  // Conditional two's-complement negate on a double-width product.
  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] x,
                                                input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  assign accept    = bus.start & ~bus.flush;
  assign signed_op = ~bus.op[0];
  assign neg_a     = signed_op & bus.rs_val[WIDTH-1];
  assign neg_b     = signed_op & bus.rt_val[WIDTH-1];

  // One iteration step of either algorithm, selected by the latched op.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_next  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_diff[WIDTH])
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign restoration of the finished magnitudes; divide by zero forces an
  // all-ones quotient while the remainder naturally reproduces rs_val.
  always_comb begin
    prod   = neg_dw(acc, neg_q);
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
      res_lo = div_zero ? '1 : neg_w(acc[WIDTH-1:0], neg_q);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; flush cancels CALC and FIX without a write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (bus.flush)             state_next = IDLE;
        else if (cnt == LAST_ITER) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, HI/LO writes and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= {{WIDTH{1'b0}}, neg_w(bus.rs_val, neg_a)};
            opnd     <= neg_w(bus.rt_val, neg_b);
            is_div   <= bus.op[1];
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
            div_zero <= bus.op[1] & (bus.rt_val == '0);
            cnt      <= '0;
          end
          if (bus.wr_en) begin
            if (bus.wr_sel) hi_q <= bus.wr_data;
            else            lo_q <= bus.wr_data;
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!bus.flush) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.rd_req | bus.wr_en);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed/unsigned results,
// divide boundaries, stall behaviour, flush, async reset and MTHI/MTLO.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for done; cyc counts edges after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.start  = 1'b1;
    tick;
    bus.start  = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.rd_req = 1'b1;
    tick;
    tick;
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=%h", bus.hi, 32'h0); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=%h", bus.lo, 32'h0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    bus.rd_req = 1'b0;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_mult;
    int cyc;
    bus.op = 2'b00; bus.rs_val = 32'hFFFFFFFD; bus.rt_val = 32'd5; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mult_busy_after_start got=%b want=1", bus.busy); end
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin tick; cyc++; end
    total++; if (cyc !== 33) begin bad++; $display("FAIL mult_latency got=%0d want=33", cyc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mult_busy_at_done got=%b want=0", bus.busy); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=%h", bus.hi, 32'hFFFFFFFF); end
    total++; if (bus.lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult_lo got=%h want=%h", bus.lo, 32'hFFFFFFF1); end
    tick;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b want=0", bus.done); end
  endtask

  task automatic test_multu_vs_mult;
    int cyc;
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL multu_latency got=%0d want=33", cyc); end
    total++; if (bus.hi !== 32'h00000001) begin bad++; $display("FAIL multu_hi got=%h want=%h", bus.hi, 32'h1); end
    total++; if (bus.lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h want=%h", bus.lo, 32'hFFFFFFFE); end
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, cyc);
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_neg1x2_hi got=%h want=%h", bus.hi, 32'hFFFFFFFF); end
    total++; if (bus.lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL mult_neg1x2_lo got=%h want=%h", bus.lo, 32'hFFFFFFFE); end
    run_op(2'b01, 32'h0001_0000, 32'h0003_0000, cyc);
    total++; if (bus.hi !== 32'h00000003) begin bad++; $display("FAIL multu_big_hi got=%h want=%h", bus.hi, 32'h3); end
    total++; if (bus.lo !== 32'h00000000) begin bad++; $display("FAIL multu_big_lo got=%h want=%h", bus.lo, 32'h0); end
  endtask

  task automatic test_div;
    int cyc;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", cyc); end
    total++; if (bus.lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=%h", bus.lo, 32'hFFFFFFFD); end
    total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=%h", bus.hi, 32'hFFFFFFFF); end
    run_op(2'b11, 32'd100, 32'd0, cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL divu_zero_latency got=%0d want=33", cyc); end
    total++; if (bus.hi !== 32'h00000064) begin bad++; $display("FAIL divu_zero_hi got=%h want=%h", bus.hi, 32'h64); end
    total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero_lo got=%h want=%h", bus.lo, 32'hFFFFFFFF); end
    run_op(2'b10, 32'hFFFFFFFB, 32'd0, cyc);
    total++; if (bus.hi !== 32'hFFFFFFFB) begin bad++; $display("FAIL div_zero_hi got=%h want=%h", bus.hi, 32'hFFFFFFFB); end
    total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_zero_lo got=%h want=%h", bus.lo, 32'hFFFFFFFF); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, cyc);
    total++; if (bus.lo !== 32'h80000000) begin bad++; $display("FAIL div_minint_lo got=%h want=%h", bus.lo, 32'h80000000); end
    total++; if (bus.hi !== 32'h00000000) begin bad++; $display("FAIL div_minint_hi got=%h want=%h", bus.hi, 32'h0); end
    run_op(2'b10, 32'd7, 32'hFFFFFFFE, cyc);
    total++; if (bus.lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_pos_neg_lo got=%h want=%h", bus.lo, 32'hFFFFFFFD); end
    total++; if (bus.hi !== 32'h00000001) begin bad++; $display("FAIL div_pos_neg_hi got=%h want=%h", bus.hi, 32'h1); end
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, cyc);
    total++; if (bus.lo !== 32'h7FFFFFFC) begin bad++; $display("FAIL divu_lo got=%h want=%h", bus.lo, 32'h7FFFFFFC); end
    total++; if (bus.hi !== 32'h00000001) begin bad++; $display("FAIL divu_hi got=%h want=%h", bus.hi, 32'h1); end
  endtask

  task automatic test_rd_stall;
    int cyc;
    int stall_bad;
    bus.op = 2'b10; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    bus.start = 1'b1; bus.rd_req = 1'b1;
    tick;
    bus.start = 1'b0;
    cyc = 0;
    stall_bad = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.stall !== 1'b1) stall_bad++;
      if (cyc == 5) begin
        bus.start = 1'b1; bus.rs_val = 32'd999; bus.rt_val = 32'd3; bus.op = 2'b11;
      end else begin
        bus.start = 1'b0;
      end
      tick;
      cyc++;
    end
    bus.start = 1'b0;
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL rd_stall_cycles_without_stall got=%0d want=0", stall_bad); end
    total++; if (cyc !== 33) begin bad++; $display("FAIL rd_div_latency got=%0d want=33", cyc); end
    total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL rd_div_hi got=%h want=%h", bus.hi, 32'd2); end
    total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL rd_div_lo got=%h want=%h", bus.lo, 32'd14); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rd_stall_at_done got=%b want=0", bus.stall); end
    bus.rd_req = 1'b0;
    tick;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL second_start_queued got=%b want=0", bus.busy); end
  endtask

  task automatic test_flush_reset;
    int seen;
    bus.op = 2'b00; bus.rs_val = 32'd7; bus.rt_val = 32'd9; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen++;
      tick;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_done_pulses got=%0d want=0", seen); end
    total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL flush_hi got=%h want=%h", bus.hi, 32'd2); end
    total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL flush_lo got=%h want=%h", bus.lo, 32'd14); end

    bus.op = 2'b00; bus.rs_val = 32'd7; bus.rt_val = 32'd9; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL async_reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL async_reset_lo got=%h want=0", bus.lo); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b want=0", bus.busy); end
    tick;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      tick;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_abort_activity got=%0d want=0", seen); end

    bus.start = 1'b1; bus.flush = 1'b1;
    tick;
    bus.start = 1'b0; bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_with_flush_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_mthi_mtlo;
    int cyc;
    int lo_bad;
    int stall_bad;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b1; bus.wr_data = 32'h12345678;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL mthi_idle_stall got=%b want=0", bus.stall); end
    tick;
    bus.wr_en = 1'b0;
    total++; if (bus.hi !== 32'h12345678) begin bad++; $display("FAIL mthi_idle_hi got=%h want=%h", bus.hi, 32'h12345678); end
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data = 32'hCAFEF00D;
    tick;
    bus.wr_en = 1'b0;
    total++; if (bus.lo !== 32'hCAFEF00D) begin bad++; $display("FAIL mtlo_idle_lo got=%h want=%h", bus.lo, 32'hCAFEF00D); end
    total++; if (bus.hi !== 32'h12345678) begin bad++; $display("FAIL mtlo_idle_hi_kept got=%h want=%h", bus.hi, 32'h12345678); end

    bus.op = 2'b01; bus.rs_val = 32'd3; bus.rt_val = 32'd4; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data = 32'hDEADBEEF;
    cyc = 0; lo_bad = 0; stall_bad = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      #1;
      if (bus.stall !== 1'b1) stall_bad++;
      if (bus.lo !== 32'hCAFEF00D) lo_bad++;
      tick;
      cyc++;
    end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL mtlo_busy_no_stall got=%0d want=0", stall_bad); end
    total++; if (lo_bad !== 0) begin bad++; $display("FAIL mtlo_busy_lo_changed got=%0d want=0", lo_bad); end
    total++; if (bus.lo !== 32'd12) begin bad++; $display("FAIL mtlo_busy_result_lo got=%h want=%h", bus.lo, 32'd12); end
    total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL mtlo_busy_result_hi got=%h want=%h", bus.hi, 32'd0); end
    tick;
    bus.wr_en = 1'b0;
    total++; if (bus.lo !== 32'hDEADBEEF) begin bad++; $display("FAIL mtlo_after_done_lo got=%h want=%h", bus.lo, 32'hDEADBEEF); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_op(2'b11, 32'd1000, 32'd7, cyc);
    total++; if (bus.lo !== 32'd142) begin bad++; $display("FAIL b2b_first_lo got=%h want=%h", bus.lo, 32'd142); end
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL b2b_second_latency got=%0d want=33", cyc); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL b2b_second_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h1) begin bad++; $display("FAIL b2b_second_lo got=%h want=1", bus.lo); end
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
    bus.flush   = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_data = '0;
    test_reset;
    test_mult;
    test_multu_vs_mult;
    test_div;
    test_rd_stall;
    test_flush_reset;
    test_mthi_mtlo;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
